// File: rtl/gt_32b_pkg.sv
// Shared definitions for the gt_32b magnitude comparator: default operand
// width, the three-way compare result type and the nibble merge helper used
// by the MSB-first priority tree.
package gt_32b_pkg;

  localparam int GT_32B_WIDTH = 32;

  typedef enum logic [1:0] {
    LT = 2'd0,
    EQ = 2'd1,
    GT = 2'd2
  } cmp_res_t;

  // Combine the verdict of the more significant nibbles with one lower nibble.
  // A decision already taken higher up always wins; only a tie so far lets the
  // lower nibble decide.
  function automatic cmp_res_t mergeNibble(input cmp_res_t upper,
                                           input logic     nibGt,
                                           input logic     nibEq);
    cmp_res_t res;
    res = upper;
    if (upper == EQ) begin
      if (nibGt) begin
        res = GT;
      end else if (!nibEq) begin
        res = LT;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/gt_32b_slice.sv
// gt_4b_slice: unsigned 4-bit nibble comparator producing greater-than and
// equal flags; less-than is implied when both are low.
module gt_4b_slice (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  output logic       o_gt,
  output logic       o_eq
);

  // Plain unsigned nibble compare; sign handling happens before the tree.
  always_comb begin
    o_gt = (i_a > i_b);
    o_eq = (i_a == i_b);
  end

endmodule

// File: rtl/gt_32b.sv
// gt_32b: registered three-way comparator (Output = a>b, eq, lt) with a
// one-cycle latency. Built from WIDTH/4 nibble slices merged MSB first.
// Optional feature macro: GT_32B_SIGNED_EN adds the signed_mode port, which
// selects two's-complement compare per cycle; without it every compare is
// unsigned.
module gt_32b
  import gt_32b_pkg::*;
#(
  parameter int WIDTH = GT_32B_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef GT_32B_SIGNED_EN
  input  logic             signed_mode,
`endif
  output logic             Output,
  output logic             eq,
  output logic             lt,
  output logic             out_valid
);

  localparam int NIBBLES = WIDTH / 4;

  logic [WIDTH-1:0]   w_a;
  logic [WIDTH-1:0]   w_b;
  logic [NIBBLES-1:0] w_sliceGt;
  logic [NIBBLES-1:0] w_sliceEq;
  cmp_res_t           w_res;

  logic r_gt;
  logic r_eq;
  logic r_lt;
  logic r_valid;

`ifdef GT_32B_SIGNED_EN
  // Flipping both sign bits maps two's-complement order onto unsigned order,
  // so the same unsigned tree serves both modes.
  always_comb begin
    w_a = {a[WIDTH-1] ^ signed_mode, a[WIDTH-2:0]};
    w_b = {b[WIDTH-1] ^ signed_mode, b[WIDTH-2:0]};
  end
`else
  // Unsigned-only build: operands go to the tree untouched.
  always_comb begin
    w_a = a;
    w_b = b;
  end
`endif

  for (genvar g = 0; g < NIBBLES; g++) begin : g_slice
    gt_4b_slice u_slice (
      .i_a  (w_a[4*g +: 4]),
      .i_b  (w_b[4*g +: 4]),
      .o_gt (w_sliceGt[g]),
      .o_eq (w_sliceEq[g])
    );
  end

  // MSB-first priority tree: the most significant differing nibble decides.
  always_comb begin
    w_res = EQ;
    for (int i = NIBBLES - 1; i >= 0; i--) begin
      w_res = mergeNibble(w_res, w_sliceGt[i], w_sliceEq[i]);
    end
  end

  // Capture a new result on every accepted edge; otherwise hold the flags and
  // drop out_valid. Reset clears everything, discarding any compare in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gt    <= 1'b0;
      r_eq    <= 1'b0;
      r_lt    <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_gt <= (w_res == GT);
        r_eq <= (w_res == EQ);
        r_lt <= (w_res == LT);
      end
    end
  end

  assign Output    = r_gt;
  assign eq        = r_eq;
  assign lt        = r_lt;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_gt_32b.sv
// Self-checking bench for gt_32b: directed corner cases, asynchronous reset
// mid-stream and a 1000-pair random back-to-back stream against a behavioural
// model. Signed cases are exercised when GT_32B_SIGNED_EN is defined.
module tb_gt_32b;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic        signed_mode;
  logic        Output;
  logic        eq;
  logic        lt;
  logic        out_valid;

  int checkCount;
  int passCount;

  // Model state: flags hold across idle edges, valid follows in_valid.
  logic expGt, expEq, expLt, expValid;

  gt_32b #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .a           (a),
    .b           (b),
`ifdef GT_32B_SIGNED_EN
    .signed_mode (signed_mode),
`endif
    .Output      (Output),
    .eq          (eq),
    .lt          (lt),
    .out_valid   (out_valid)
  );

  // Free-running 10-unit clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare {out_valid, Output, eq, lt} against the expected pattern.
  task automatic checkOutput(input string tag, input logic [3:0] observed,
                             input logic [3:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got {v,gt,eq,lt}=%b expected %b at %0t",
               tag, observed, expected, $time);
    end
  endtask

  // Reference: plain arithmetic relational operators on the raw operands.
  task automatic modelEdge(input logic v, input logic [31:0] x,
                           input logic [31:0] y, input logic sm);
    logic useSigned;
`ifdef GT_32B_SIGNED_EN
    useSigned = sm;
`else
    useSigned = 1'b0;
    if (sm) useSigned = 1'b0;
`endif
    expValid = v;
    if (v) begin
      if (useSigned) begin
        expGt = ($signed(x) >  $signed(y));
        expEq = (x == y);
        expLt = ($signed(x) <  $signed(y));
      end else begin
        expGt = (x >  y);
        expEq = (x == y);
        expLt = (x <  y);
      end
    end
  endtask

  // Drive one cycle of inputs at the falling edge, let a rising edge pass,
  // then compare #1 later.
  task automatic applyStimulus(input string tag, input logic v,
                               input logic [31:0] x, input logic [31:0] y,
                               input logic sm);
    @(negedge clk);
    in_valid    = v;
    a           = x;
    b           = y;
    signed_mode = sm;
    @(posedge clk);
    modelEdge(v, x, y, sm);
    #1;
    checkOutput(tag, {out_valid, Output, eq, lt},
                {expValid, expGt, expEq, expLt});
  endtask

  task automatic clearModel();
    expGt    = 1'b0;
    expEq    = 1'b0;
    expLt    = 1'b0;
    expValid = 1'b0;
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rsm;
    checkCount  = 0;
    passCount   = 0;
    rst         = 1'b1;
    in_valid    = 1'b0;
    a           = '0;
    b           = '0;
    signed_mode = 1'b0;
    clearModel();

    #2;
    checkOutput("reset_state", {out_valid, Output, eq, lt}, 4'b0000);
    @(posedge clk);
    #1;
    checkOutput("reset_held", {out_valid, Output, eq, lt}, 4'b0000);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus("one_gt_zero",  1'b1, 32'd1, 32'd0, 1'b0);
    applyStimulus("one_eq_one",   1'b1, 32'd1, 32'd1, 1'b0);
    applyStimulus("zero_lt_one",  1'b1, 32'd0, 32'd1, 1'b0);
    applyStimulus("zero_eq_zero", 1'b1, 32'd0, 32'd0, 1'b0);
    applyStimulus("idle_hold",    1'b0, 32'd9, 32'd2, 1'b0);
    applyStimulus("idle_hold2",   1'b0, 32'd0, 32'd7, 1'b0);
    applyStimulus("max_gt_zero",  1'b1, 32'hFFFFFFFF, 32'd0, 1'b0);
    applyStimulus("zero_lt_max",  1'b1, 32'd0, 32'hFFFFFFFF, 1'b0);
    applyStimulus("max_eq_max",   1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    applyStimulus("msb_unsigned", 1'b1, 32'h80000000, 32'h7FFFFFFF, 1'b0);
    applyStimulus("nibble_carry", 1'b1, 32'h00010000, 32'h0000FFFF, 1'b0);
    applyStimulus("low_nibble",   1'b1, 32'h12345677, 32'h12345678, 1'b0);
`ifdef GT_32B_SIGNED_EN
    applyStimulus("msb_signed",   1'b1, 32'h80000000, 32'h7FFFFFFF, 1'b1);
    applyStimulus("neg1_lt_zero", 1'b1, 32'hFFFFFFFF, 32'd0, 1'b1);
    applyStimulus("neg_vs_neg",   1'b1, 32'hFFFFFFFE, 32'hFFFFFFFF, 1'b1);
    applyStimulus("signed_eq",    1'b1, 32'h80000000, 32'h80000000, 1'b1);
`endif

    // Asynchronous reset between edges while a stream is running.
    applyStimulus("pre_reset",    1'b1, 32'd100, 32'd3, 1'b0);
    @(negedge clk);
    in_valid = 1'b1;
    a        = 32'd4;
    b        = 32'd40;
    #2;
    rst = 1'b1;
    clearModel();
    #1;
    checkOutput("async_reset", {out_valid, Output, eq, lt}, 4'b0000);
    @(posedge clk);
    #1;
    checkOutput("reset_discard", {out_valid, Output, eq, lt}, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus("post_reset",   1'b1, 32'd5, 32'd9, 1'b0);

    // Random back-to-back stream; occasional corner operands mixed in.
    for (int i = 0; i < 1000; i++) begin
      ra  = $urandom;
      rb  = $urandom;
      rsm = 1'(($urandom >> 3) & 1);
      case ($urandom_range(0, 7))
        0: rb = ra;
        1: rb = ra ^ (32'h1 << $urandom_range(0, 31));
        2: ra = 32'hFFFFFFFF;
        3: rb = 32'h80000000;
        default: ;
      endcase
`ifndef GT_32B_SIGNED_EN
      rsm = 1'b0;
`endif
      applyStimulus("random", 1'b1, ra, rb, rsm);
    end
    applyStimulus("final_idle", 1'b0, 32'd0, 32'd0, 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  // Hard bound so the bench always ends.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not complete, got no finish expected finish");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/gt_32b.md
GT_32B -- requirements
Module: gt_32b

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits; only 32 is required to be supported.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 in_valid  input  1  operands a/b are presented for comparison this cycle.
REQ-005 a  input  WIDTH  left operand.
REQ-006 b  input  WIDTH  right operand.
REQ-007 signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; present only when GT_32B_SIGNED_EN is defined.
REQ-008 Output  output  1  registered result, 1 when a > b, else 0.
REQ-009 eq  output  1  registered result, 1 when a == b.
REQ-010 lt  output  1  registered result, 1 when a < b.
REQ-011 out_valid  output  1  Output/eq/lt hold the result of an accepted comparison.

Function
REQ-012 Strict compare: equal operands give Output=0, eq=1, lt=0.
REQ-013 Exactly one of Output, eq and lt is 1 whenever out_valid=1.
REQ-014 Fixed latency: operands sampled on a clk edge with in_valid=1 produce results and out_valid=1 after that same edge (1-cycle latency).
REQ-015 Edge with in_valid=0: out_valid goes 0; Output/eq/lt hold their last values.
REQ-016 Back-to-back in_valid accepts a new comparison every cycle, no stalls; the design has no ready signal.
REQ-017 Unsigned compare covers the full range 0..2^32-1: a=32'hFFFFFFFF, b=0 gives Output=1.
REQ-018 Signed compare (GT_32B_SIGNED_EN with signed_mode=1) uses two's complement: a=32'hFFFFFFFF (-1), b=0 gives Output=0, lt=1.
REQ-019 The compare is combinational from the sampled a/b; only the outputs are registered.
REQ-020 No input combination produces X on the outputs after reset.

Reset
REQ-021 While rst=1: Output=0, eq=0, lt=0, out_valid=0, immediately and independent of clk.
REQ-022 A comparison in flight when rst asserts is discarded.
REQ-023 The first in_valid edge after rst deasserts is accepted normally.

Configuration
REQ-024 Macro GT_32B_SIGNED_EN: when defined, the signed_mode port exists and selects signed or unsigned compare per cycle.
REQ-025 When GT_32B_SIGNED_EN is not defined, the signed_mode port is absent and all compares are unsigned.

Structure
REQ-026 Package gt_32b_pkg holds the WIDTH default constant and a typedef cmp_res_t (2-bit enum: LT, EQ, GT).
REQ-027 One sub-module gt_4b_slice: a 4-bit nibble comparator with gt/eq outputs.
REQ-028 Eight gt_4b_slice instances are combined in an MSB-first priority tree to form the 32-bit result.
REQ-029 Signed mode is implemented by inverting the operand MSBs before the tree.

Verification
REQ-030 a=1, b=0, in_valid=1 -> next cycle Output=1, eq=0, lt=0, out_valid=1.
REQ-031 a=1, b=1 -> Output=0, eq=1; then a=0, b=1 -> Output=0, lt=1; then a=0, b=0 -> Output=0, eq=1.
REQ-032 a=32'h80000000, b=32'h7FFFFFFF, unsigned -> Output=1; same operands with signed_mode=1 -> Output=0, lt=1.
REQ-033 a=32'h00010000, b=32'h0000FFFF -> Output=1, exercising a carry across nibble boundaries.
REQ-034 Assert rst asynchronously between edges during a stream of in_valid -> all outputs 0 at once; first compare after release is correct.
REQ-035 Random back-to-back stream of 1000 operand pairs -> each result matches a reference model exactly one cycle later.
